// File: rtl/requant_pkg.sv
// Shared types and constants for the multi-lane requantiser.
// Widths, saturation bounds, per-stage config bundles and the clip helper.
package requant_pkg;

  localparam int LANES   = 4;
  localparam int IN_W    = 32;
  localparam int GAIN_W  = 16;
  localparam int BIAS_W  = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 6;
  localparam int SAT_W   = 16;

  localparam int P_W    = IN_W + GAIN_W;
  localparam int P1_W   = P_W + 1;
  localparam int P2_W   = P_W + 2;
  localparam int NSAT_W = $clog2(LANES + 1);

  // Largest shift whose rounding bit still lands inside the sum
  localparam logic [SHIFT_W-1:0] RND_MAX_SH = SHIFT_W'(P_W);
  localparam logic signed [P1_W-1:0] RND_ONE = P1_W'(1);

  localparam logic signed [P2_W-1:0] SAT_HI =
    P2_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [P2_W-1:0] SAT_LO = ~SAT_HI;

  localparam logic signed [OUT_W-1:0] OUT_HI =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_LO =
    {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic signed [GAIN_W-1:0] gain;
    logic signed [BIAS_W-1:0] bias;
    logic [SHIFT_W-1:0]       shift;
    logic                     round_en;
    logic                     relu_en;
  } cfg_t;

  // Config still needed once the product is formed
  typedef struct packed {
    logic signed [BIAS_W-1:0] bias;
    logic [SHIFT_W-1:0]       shift;
    logic                     round_en;
    logic                     relu_en;
  } shf_cfg_t;

  // Config still needed once the shift is done
  typedef struct packed {
    logic signed [BIAS_W-1:0] bias;
    logic                     relu_en;
  } act_cfg_t;

  typedef struct packed {
    logic                    hit;
    logic signed [OUT_W-1:0] val;
  } sat_t;

  function automatic sat_t sat_clip(
    input logic signed [P2_W-1:0] v
  );
    sat_t r;
    r.hit = 1'b1;
    r.val = OUT_HI;
    if (v > SAT_HI) begin
      r.val = OUT_HI;
    end else if (v < SAT_LO) begin
      r.val = OUT_LO;
    end else begin
      r.hit = 1'b0;
      r.val = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantiser: multiply, round+shift, bias/ReLU/saturate.
// Stage enables come from the shared stall chain in the top level.
module requant_lane
  import requant_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_en2,
  input  logic                     i_en3,
  input  logic                     i_en4,
  input  logic signed [IN_W-1:0]   i_x,
  input  logic signed [GAIN_W-1:0] i_gain,
  input  logic [SHIFT_W-1:0]       i_shift,
  input  logic                     i_round_en,
  input  logic signed [BIAS_W-1:0] i_bias,
  input  logic                     i_relu_en,
  output logic signed [OUT_W-1:0]  o_y,
  output logic                     o_hit
);

  logic signed [P_W-1:0]  r_prod;
  logic signed [P1_W-1:0] r_shf;
  logic signed [OUT_W-1:0] r_y;
  logic signed [P1_W-1:0] w_rnd;
  logic signed [P1_W-1:0] w_sum;
  logic signed [P2_W-1:0] w_bias;
  logic signed [P2_W-1:0] w_act;
  sat_t                   w_clip;

  // Product register, fed from the registered S1 operands
  always_ff @(posedge clk) begin
    if (i_en2) begin
      r_prod <= P_W'(i_x) * P_W'(i_gain);
    end
  end

  // Round-half-up bias; dropped once the shift passes the sum width
  always_comb begin
    w_rnd = '0;
    if (i_round_en && (i_shift != '0) && (i_shift <= RND_MAX_SH)) begin
      w_rnd = RND_ONE << (i_shift - SHIFT_W'(1));
    end
    w_sum = P1_W'(r_prod) + w_rnd;
  end

  // Arithmetic shift result register
  always_ff @(posedge clk) begin
    if (i_en3) begin
      r_shf <= w_sum >>> i_shift;
    end
  end

  // Bias add, ReLU and clip feeding the output register
  always_comb begin
    w_bias = P2_W'(r_shf) + P2_W'(i_bias);
    w_act  = (i_relu_en && w_bias[P2_W-1]) ? '0 : w_bias;
    w_clip = sat_clip(w_act);
  end

  // Output register, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y <= '0;
    end else if (i_en4) begin
      r_y <= w_clip.val;
    end
  end

  assign o_y   = r_y;
  assign o_hit = w_clip.hit;

endmodule

// File: rtl/requant_lanes.sv
// Multi-lane requantiser top: capture stage, stall chain, lanes, sat counter.
// Four stages; config rides with its beat through the pipeline.
module requant_lanes
  import requant_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  input  logic signed [GAIN_W-1:0] cfg_gain,
  input  logic signed [BIAS_W-1:0] cfg_bias,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_round_en,
  input  logic                     cfg_relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  input  logic                     sat_clr,
  output logic [SAT_W-1:0]         sat_count
);

  logic r_v1, r_v2, r_v3, r_v4;
  logic w_ld1, w_ld2, w_ld3, w_ld4;
  logic w_en1, w_en2, w_en3, w_en4;

  logic [LANES*IN_W-1:0] r_x1;
  cfg_t                  r_cfg1;
  shf_cfg_t              r_cfg2;
  act_cfg_t              r_cfg3;

  logic [LANES-1:0]  w_hit;
  logic [NSAT_W-1:0] w_nsat;
  logic [SAT_W-1:0]  w_base;
  logic [SAT_W:0]    w_sum;
  logic [SAT_W-1:0]  r_sat;

  // Stall chain: a stage loads when empty or when its successor loads
  always_comb begin
    w_ld4 = !r_v4 || out_ready;
    w_ld3 = !r_v3 || w_ld4;
    w_ld2 = !r_v2 || w_ld3;
    w_ld1 = !r_v1 || w_ld2;
    w_en1 = w_ld1 && in_valid;
    w_en2 = w_ld2 && r_v1;
    w_en3 = w_ld3 && r_v2;
    w_en4 = w_ld4 && r_v3;
  end

  assign in_ready  = w_ld1;
  assign out_valid = r_v4;

  // Stage valid flags; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
      if (w_ld4) r_v4 <= r_v3;
    end
  end

  // S1 capture and config hand-off alongside each beat
  always_ff @(posedge clk) begin
    if (w_en1) begin
      r_x1   <= in_data;
      r_cfg1 <= '{gain:     cfg_gain,
                  bias:     cfg_bias,
                  shift:    cfg_shift,
                  round_en: cfg_round_en,
                  relu_en:  cfg_relu_en};
    end
    if (w_en2) begin
      r_cfg2 <= '{bias:     r_cfg1.bias,
                  shift:    r_cfg1.shift,
                  round_en: r_cfg1.round_en,
                  relu_en:  r_cfg1.relu_en};
    end
    if (w_en3) begin
      r_cfg3 <= '{bias:    r_cfg2.bias,
                  relu_en: r_cfg2.relu_en};
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_en2      (w_en2),
      .i_en3      (w_en3),
      .i_en4      (w_en4),
      .i_x        (r_x1[i*IN_W +: IN_W]),
      .i_gain     (r_cfg1.gain),
      .i_shift    (r_cfg2.shift),
      .i_round_en (r_cfg2.round_en),
      .i_bias     (r_cfg3.bias),
      .i_relu_en  (r_cfg3.relu_en),
      .o_y        (out_data[i*OUT_W +: OUT_W]),
      .o_hit      (w_hit[i])
    );
  end

  // Sum this cycle's saturation events; clear wins over the old total
  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < LANES; i++) begin
      w_nsat = w_nsat + NSAT_W'(w_hit[i]);
    end
    w_base = sat_clr ? '0 : r_sat;
    w_sum  = {1'b0, w_base} + (SAT_W+1)'(w_en4 ? w_nsat : '0);
  end

  // Saturating event counter, sticks at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= '0;
    end else begin
      r_sat <= w_sum[SAT_W] ? '1 : w_sum[SAT_W-1:0];
    end
  end

  assign sat_count = r_sat;

endmodule
